// File: rtl/approx_add_pipe.sv
// Pipelined approximate adder: lower K bits OR-approximated, upper bits added exactly,
// valid/ready handshake. Define APPROX_ADD_ERRMON_EN to add the on-line error monitor.
module approx_add_pipe #(
    parameter int W      = 8,
    parameter int K      = 2,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_a,
    input  logic [W-1:0]        in_b,
    input  logic                in_exact,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W:0]          out_sum
`ifdef APPROX_ADD_ERRMON_EN
    ,
    input  logic                mon_clr,
    output logic [CNT_W-1:0]    mon_samples,
    output logic [CNT_W-1:0]    mon_errs,
    output logic [W:0]          mon_max_err,
    output logic [CNT_W+W-1:0]  mon_sum_err
`endif
);

    if (W < 2 || K < 0 || K >= W || STAGES < 1 || STAGES > 4 || CNT_W < 1) begin : g_bad_params
        $error("approx_add_pipe: illegal parameter combination");
    end

    // Lower-part OR below K; carry into bit K comes from the top approximated bit pair.
    function automatic logic [W:0] approx_sum_f(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] r;
        logic       c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i < K) begin
                r[i] = a[i] | b[i];
                if (i == K - 1) begin
                    c = a[i] & b[i];
                end else begin
                    c = 1'b0;
                end
            end else begin
                r[i] = a[i] ^ b[i] ^ c;
                c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            end
        end
        r[W] = c;
        return r;
    endfunction

    logic [W:0] approx_s;
    logic [W:0] exact_s;
    logic [W:0] sum_s;
    logic       adv_s;

    logic       valid_r [STAGES];
    logic [W:0] sum_r   [STAGES];

    // Stage-1 combinational arithmetic and mode select.
    always_comb begin
        approx_s = approx_sum_f(in_a, in_b);
        exact_s  = {1'b0, in_a} + {1'b0, in_b};
        if (in_exact) begin
            sum_s = exact_s;
        end else begin
            sum_s = approx_s;
        end
    end

    assign adv_s     = out_ready | ~out_valid;
    assign in_ready  = adv_s;
    assign out_valid = valid_r[STAGES-1];
    assign out_sum   = sum_r[STAGES-1];

    // Lock-step pipeline: every stage shifts on adv, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_r[s] <= 1'b0;
                sum_r[s]   <= '0;
            end
        end else if (adv_s) begin
            valid_r[0] <= in_valid;
            sum_r[0]   <= sum_s;
            for (int s = 1; s < STAGES; s++) begin
                valid_r[s] <= valid_r[s-1];
                sum_r[s]   <= sum_r[s-1];
            end
        end
    end

`ifdef APPROX_ADD_ERRMON_EN
    logic [W:0]       exact_r [STAGES];
    logic             mode_r  [STAGES];
    logic [W:0]       err_s;
    logic             xfer_s;
    logic [CNT_W+W:0] sum_ext_s;

    // Shadow exact sum and mode bit travel alongside the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                exact_r[s] <= '0;
                mode_r[s]  <= 1'b0;
            end
        end else if (adv_s) begin
            exact_r[0] <= exact_s;
            mode_r[0]  <= in_exact;
            for (int s = 1; s < STAGES; s++) begin
                exact_r[s] <= exact_r[s-1];
                mode_r[s]  <= mode_r[s-1];
            end
        end
    end

    // Absolute error of the delivered result and saturating accumulator sum.
    always_comb begin
        err_s  = '0;
        xfer_s = out_valid & out_ready;
        if (mode_r[STAGES-1]) begin
            err_s = '0;
        end else if (exact_r[STAGES-1] >= sum_r[STAGES-1]) begin
            err_s = exact_r[STAGES-1] - sum_r[STAGES-1];
        end else begin
            err_s = sum_r[STAGES-1] - exact_r[STAGES-1];
        end
        sum_ext_s = {1'b0, mon_sum_err} + (CNT_W+W+1)'(err_s);
    end

    // Saturating monitor counters; a clear beats a coincident transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_samples <= '0;
            mon_errs    <= '0;
            mon_max_err <= '0;
            mon_sum_err <= '0;
        end else if (mon_clr) begin
            mon_samples <= '0;
            mon_errs    <= '0;
            mon_max_err <= '0;
            mon_sum_err <= '0;
        end else if (xfer_s) begin
            if (mon_samples != {CNT_W{1'b1}}) begin
                mon_samples <= mon_samples + CNT_W'(1);
            end
            if (err_s != '0 && mon_errs != {CNT_W{1'b1}}) begin
                mon_errs <= mon_errs + CNT_W'(1);
            end
            if (err_s > mon_max_err) begin
                mon_max_err <= err_s;
            end
            if (sum_ext_s[CNT_W+W]) begin
                mon_sum_err <= {(CNT_W+W){1'b1}};
            end else begin
                mon_sum_err <= sum_ext_s[CNT_W+W-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed self-checking bench for approx_add_pipe (W=8, K=2, STAGES=2).
// Monitor checks compile only when APPROX_ADD_ERRMON_EN is defined.
module tb_approx_add_pipe;

    localparam int W      = 8;
    localparam int K      = 2;
    localparam int STAGES = 2;
    localparam int CNT_W  = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_exact;
    logic             out_valid;
    logic             out_ready;
    logic [W:0]       out_sum;
`ifdef APPROX_ADD_ERRMON_EN
    logic             mon_clr;
    logic [CNT_W-1:0] mon_samples;
    logic [CNT_W-1:0] mon_errs;
    logic [W:0]       mon_max_err;
    logic [CNT_W+W-1:0] mon_sum_err;
`endif

    int checks_cnt;
    int fail_cnt;

    approx_add_pipe #(.W(W), .K(K), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_exact   (in_exact),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum)
`ifdef APPROX_ADD_ERRMON_EN
        ,
        .mon_clr    (mon_clr),
        .mon_samples(mon_samples),
        .mon_errs   (mon_errs),
        .mon_max_err(mon_max_err),
        .mon_sum_err(mon_sum_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction: checks latency of exactly STAGES and the result.
    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic ex,
                           input logic [8:0] exp);
        in_a = a; in_b = b; in_exact = ex; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check_val("one_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check_val("one_lat1_valid", 64'(out_valid), 64'd0);
        step();
        check_val("one_lat2_valid", 64'(out_valid), 64'd1);
        check_val("one_sum", 64'(out_sum), 64'(exp));
        step();
        check_val("one_drain_valid", 64'(out_valid), 64'd0);
    endtask

`ifdef APPROX_ADD_ERRMON_EN
    task automatic check_mon(input int smp, input int errs, input int mx, input int se);
        check_val("mon_samples", 64'(mon_samples), 64'(smp));
        check_val("mon_errs", 64'(mon_errs), 64'(errs));
        check_val("mon_max_err", 64'(mon_max_err), 64'(mx));
        check_val("mon_sum_err", 64'(mon_sum_err), 64'(se));
    endtask
`endif

    logic [7:0] st_a    [6];
    logic [8:0] st_exp  [6];
    int         st_cyc  [6];

    initial begin
        int sent;
        int recv;
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_exact = 1'b0; out_ready = 1'b1;
`ifdef APPROX_ADD_ERRMON_EN
        mon_clr = 1'b0;
`endif
        #2;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_sum", 64'(out_sum), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef APPROX_ADD_ERRMON_EN
        check_mon(0, 0, 0, 0);
`endif
        step();
        step();
        rst_n = 1'b1;
        step();

        run_one(8'h03, 8'h03, 1'b0, 9'h007);
`ifdef APPROX_ADD_ERRMON_EN
        check_mon(1, 1, 1, 1);
`endif
        run_one(8'hFF, 8'h01, 1'b0, 9'h0FF);
`ifdef APPROX_ADD_ERRMON_EN
        check_mon(2, 2, 1, 2);
`endif
        run_one(8'hFF, 8'hFF, 1'b0, 9'h1FF);
`ifdef APPROX_ADD_ERRMON_EN
        check_mon(3, 3, 1, 3);
`endif
        run_one(8'h03, 8'h03, 1'b1, 9'h006);
`ifdef APPROX_ADD_ERRMON_EN
        check_mon(4, 3, 1, 3);
`endif
        run_one(8'h10, 8'h20, 1'b0, 9'h030);
        run_one(8'h02, 8'h02, 1'b0, 9'h006);
`ifdef APPROX_ADD_ERRMON_EN
        check_mon(6, 4, 2, 5);
`endif

        // Stream of 6 with out_ready low in cycles 4..6; b=0x04 keeps the sums exact.
        st_a   = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h41, 8'h51};
        st_exp = '{9'h005, 9'h015, 9'h025, 9'h035, 9'h045, 9'h055};
        st_cyc = '{2, 3, 7, 8, 9, 10};
        sent = 0;
        recv = 0;
        for (int c = 0; c < 14; c++) begin
            out_ready = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
            in_valid  = (sent < 6) ? 1'b1 : 1'b0;
            in_a      = (sent < 6) ? st_a[sent] : 8'h00;
            in_b      = 8'h04;
            in_exact  = 1'b0;
            #1;
            if (c >= 4 && c <= 6) begin
                check_val("stall_in_ready", 64'(in_ready), 64'd0);
                check_val("stall_out_valid", 64'(out_valid), 64'd1);
                check_val("stall_out_sum", 64'(out_sum), 64'(st_exp[2]));
            end
            if (out_valid && out_ready) begin
                if (recv < 6) begin
                    check_val("stream_sum", 64'(out_sum), 64'(st_exp[recv]));
                    check_val("stream_cycle", 64'(c), 64'(st_cyc[recv]));
                end else begin
                    check_val("stream_extra", 64'(recv), 64'd6);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_val("stream_recv", 64'(recv), 64'd6);
`ifdef APPROX_ADD_ERRMON_EN
        check_mon(12, 4, 2, 5);
`endif

        // Async reset with two transactions in flight.
        in_a = 8'h03; in_b = 8'h03; in_valid = 1'b1;
        step();
        in_a = 8'hFF; in_b = 8'hFF;
        step();
        in_valid = 1'b0;
        check_val("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 64'(out_valid), 64'd0);
        check_val("async_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef APPROX_ADD_ERRMON_EN
        check_mon(0, 0, 0, 0);
`endif
        step();
        rst_n = 1'b1;
        step();
        check_val("post_rst_idle", 64'(out_valid), 64'd0);
        run_one(8'h10, 8'h20, 1'b0, 9'h030);

`ifdef APPROX_ADD_ERRMON_EN
        // Clear coinciding with an output transfer wins.
        check_mon(1, 0, 0, 0);
        in_a = 8'h03; in_b = 8'h03; in_exact = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_val("clr_xfer_valid", 64'(out_valid), 64'd1);
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
        check_mon(0, 0, 0, 0);
        step();
        check_mon(0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
